// File: rtl/range_adjust_pipe_if.sv
// Stream and configuration bundle for range_adjust_pipe.
// master: the side that feeds beats/config and sinks results; slave: the adjuster itself.
interface range_adjust_pipe_if #(
    parameter int unsigned W = 4
) ();
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic [1:0]   out_region;
    logic         cfg_wr;
    logic [W-1:0] cfg_lo;
    logic [W-1:0] cfg_hi;

    modport master (
        output in_valid, in_data, out_ready, cfg_wr, cfg_lo, cfg_hi,
        input  in_ready, out_valid, out_data, out_region
    );

    modport slave (
        input  in_valid, in_data, out_ready, cfg_wr, cfg_lo, cfg_hi,
        output in_ready, out_valid, out_data, out_region
    );
endinterface

// File: rtl/range_adjust_pipe.sv
// range_adjust_pipe: single registered stage that nudges each value toward a
// configurable band. Below lo -> +STEP (saturating), inside [lo,hi) -> -STEP
// (saturating at 0), otherwise passed through. Optional per-region statistics
// counters are built when RANGE_ADJUST_STATS_EN is defined.
module range_adjust_pipe #(
    parameter int unsigned W      = 4,
    parameter int unsigned STEP   = 1,
    parameter int unsigned LO_RST = 6,
    parameter int unsigned HI_RST = 11,
    parameter int unsigned CW     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    range_adjust_pipe_if.slave bus
`ifdef RANGE_ADJUST_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [CW-1:0]     cnt_inc,
    output logic [CW-1:0]     cnt_dec,
    output logic [CW-1:0]     cnt_pass
`endif
);
    typedef enum logic [1:0] {
        RegInc  = 2'b00,
        RegDec  = 2'b01,
        RegPass = 2'b10
    } region_e;

    logic [W-1:0] lo_q, lo_d;
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] data_q, data_d;
    region_e      region_q, region_d;
    logic         valid_q, valid_d;

    logic         ready;
    logic         accept;
    region_e      in_region;
    logic [W-1:0] adj;
    logic [W:0]   sum;
    logic [W:0]   diff;

    assign ready          = !valid_q || bus.out_ready;
    assign accept         = bus.in_valid && ready;
    assign bus.in_ready   = ready;
    assign bus.out_valid  = valid_q;
    assign bus.out_data   = data_q;
    assign bus.out_region = region_q;

    // Classify the incoming value and compute its adjusted result at W+1 bits.
    always_comb begin
        sum  = {1'b0, bus.in_data} + (W+1)'(STEP);
        diff = {1'b0, bus.in_data} - (W+1)'(STEP);
        if (bus.in_data < lo_q) begin
            in_region = RegInc;
            adj       = sum[W] ? '1 : sum[W-1:0];
        end else if (bus.in_data < hi_q) begin
            in_region = RegDec;
            // Top bit set means the subtraction borrowed.
            adj       = diff[W] ? '0 : diff[W-1:0];
        end else begin
            in_region = RegPass;
            adj       = bus.in_data;
        end
    end

    // Next state of the output register and thresholds.
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        region_d = region_q;
        if (accept) begin
            valid_d  = 1'b1;
            data_d   = adj;
            region_d = in_region;
        end else if (bus.out_ready) begin
            valid_d  = 1'b0;
        end
        // New thresholds only affect beats accepted on later edges.
        lo_d = bus.cfg_wr ? bus.cfg_lo : lo_q;
        hi_d = bus.cfg_wr ? bus.cfg_hi : hi_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            region_q <= RegInc;
            lo_q     <= W'(LO_RST);
            hi_q     <= W'(HI_RST);
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            region_q <= region_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
        end
    end

`ifdef RANGE_ADJUST_STATS_EN
    logic [CW-1:0] inc_q, inc_d;
    logic [CW-1:0] dec_q, dec_d;
    logic [CW-1:0] pass_q, pass_d;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == '1) ? c : c + CW'(1);
    endfunction

    // Count accepted beats per region; clear wins over a coincident beat.
    always_comb begin
        inc_d  = inc_q;
        dec_d  = dec_q;
        pass_d = pass_q;
        if (stat_clr) begin
            inc_d  = '0;
            dec_d  = '0;
            pass_d = '0;
        end else if (accept) begin
            case (in_region)
                RegInc:  inc_d  = sat_inc(inc_q);
                RegDec:  dec_d  = sat_inc(dec_q);
                default: pass_d = sat_inc(pass_q);
            endcase
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inc_q  <= '0;
            dec_q  <= '0;
            pass_q <= '0;
        end else begin
            inc_q  <= inc_d;
            dec_q  <= dec_d;
            pass_q <= pass_d;
        end
    end

    assign cnt_inc  = inc_q;
    assign cnt_dec  = dec_q;
    assign cnt_pass = pass_q;
`else
    // Counter width has no role without the statistics block.
    logic unused_cw;
    assign unused_cw = (CW == 0);
`endif
endmodule
